// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
//
// Block-granular data memory that responds to a cache controller's memory
// interface. It holds 2**ADDR_W blocks of DATA_W bits and imitates a slow
// main memory by stalling the requester for a fixed LATENCY.
//
// Each request goes through IDLE -> BUSY -> DONE -> IDLE. DONE is a single
// cycle in which requests are ignored. This gives the initiator one cycle
// to drop (or switch) its request after busywait falls.
//
// Optional feature (macro DMEM_ACCESS_CNT_EN):
//   Adds the rd_count and wr_count outputs. These are 16-bit wrapping
//   counters of completed reads and completed writes.
//
// Parameters:
//   LATENCY  cycles from acceptance to completion (values < 1 act as 1)
//   ADDR_W   block address width
//   DATA_W   block width in bits
//
// Ports:
//   clock          system clock, all state changes on posedge
//   reset          synchronous, active-high
//   mem_read       read request, held until busywait falls
//   mem_write      write request, held until busywait falls
//   mem_address    block address
//   mem_writedata  block to write
//   mem_readdata   fetched block (registered, held until the next read)
//   mem_busywait   combinational stall to the initiator
//   mem_err        sticky flag: read and write requested together
//   rd_count       completed reads   (DMEM_ACCESS_CNT_EN only)
//   wr_count       completed writes  (DMEM_ACCESS_CNT_EN only)
// ---------------------------------------------------------------------------
module block_data_memory #(
  parameter int LATENCY = 5,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_writedata,
  output logic [DATA_W-1:0] mem_readdata,
  output logic              mem_busywait,
  output logic              mem_err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int LAT   = (LATENCY < 1) ? 1 : LATENCY;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_q;     // 1 = write, 0 = read

  logic [DATA_W-1:0] mem_array [DEPTH];

  logic req;
  logic illegal;
  logic complete;

  // A legal request is exactly one of read or write.
  assign req      = mem_read ^ mem_write;
  assign illegal  = mem_read & mem_write;
  assign complete = (state == BUSY) && (counter == '0);

  // Busywait rises in the same cycle that a legal request appears in IDLE.
  // It falls right after the completing edge moves the FSM into DONE.
  assign mem_busywait = (state == BUSY) || ((state == IDLE) && req);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge and ordering cannot race.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= 1'b0;
      mem_readdata <= '0;
      mem_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (illegal) begin
            mem_err <= 1'b1;
          end else if (req) begin
            addr_q  <= mem_address;
            wdata_q <= mem_writedata;
            op_q    <= mem_write;
            counter <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (counter == '0) begin
            if (!op_q) begin
              mem_readdata <= mem_array[addr_q];
            end
            state <= DONE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the storage array has no reset branch. Clearing it would need a
  // port per word and would rule out RAM inference. Only the commit is gated
  // by reset, so a reset during BUSY drops the pending write.
  always_ff @(posedge clock) begin
    if (!reset && complete && op_q) begin
      mem_array[addr_q] <= wdata_q;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  // Completed-access counters. They wrap naturally at 16'hFFFF.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (complete) begin
      if (op_q) begin
        wr_count <= wr_count + 16'd1;
      end else begin
        rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
// ---------------------------------------------------------------------------
// tb_block_data_memory
//
// Directed self-checking bench for block_data_memory. The bench has two
// instances:
//   dut   default LATENCY = 5
//   dut1  LATENCY = 1
//
// All inputs are driven on the negative edge and all outputs are sampled
// there as well. "edges" counts every posedge from the first posedge with
// the request present up to the completing edge, inclusive. The expected
// count is therefore LATENCY + 1.
// ---------------------------------------------------------------------------
module tb_block_data_memory;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [5:0]  mem_address = '0;
  logic [31:0] mem_writedata = '0;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic        mem_err;

  logic        mem_read_l1 = 1'b0;
  logic        mem_write_l1 = 1'b0;
  logic [5:0]  mem_address_l1 = '0;
  logic [31:0] mem_writedata_l1 = '0;
  logic [31:0] mem_readdata_l1;
  logic        mem_busywait_l1;
  logic        mem_err_l1;

`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic [15:0] rd_count_l1;
  logic [15:0] wr_count_l1;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  block_data_memory #(.LATENCY(5), .ADDR_W(6), .DATA_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .mem_err       (mem_err)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count      (rd_count),
    .wr_count      (wr_count)
`endif
  );

  block_data_memory #(.LATENCY(1), .ADDR_W(6), .DATA_W(32)) dut1 (
    .clock         (clock),
    .reset         (reset),
    .mem_read      (mem_read_l1),
    .mem_write     (mem_write_l1),
    .mem_address   (mem_address_l1),
    .mem_writedata (mem_writedata_l1),
    .mem_readdata  (mem_readdata_l1),
    .mem_busywait  (mem_busywait_l1),
    .mem_err       (mem_err_l1)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count      (rd_count_l1),
    .wr_count      (wr_count_l1)
`endif
  );

  // Counts posedges until busywait is low at a negedge. The count is
  // bounded, so a stuck DUT shows up as a wrong edge count.
  task automatic wait0(output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end while (mem_busywait && edges < 40);
  endtask

  task automatic wait1(output int edges);
    edges = 0;
    do begin
      @(posedge clock);
      edges++;
      @(negedge clock);
    end while (mem_busywait_l1 && edges < 40);
  endtask

  // One complete request on dut. The FSM must be in IDLE by the next negedge.
  task automatic req0(input logic rd, input logic wr, input logic [5:0] addr,
                      input logic [31:0] data, output logic bw_first,
                      output int edges, output logic [31:0] rdata);
    @(negedge clock);
    mem_read      = rd;
    mem_write     = wr;
    mem_address   = addr;
    mem_writedata = data;
    #1 bw_first = mem_busywait;
    wait0(edges);
    rdata     = mem_readdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic req1(input logic rd, input logic wr, input logic [5:0] addr,
                      input logic [31:0] data, output int edges,
                      output logic [31:0] rdata);
    @(negedge clock);
    mem_read_l1      = rd;
    mem_write_l1     = wr;
    mem_address_l1   = addr;
    mem_writedata_l1 = data;
    wait1(edges);
    rdata        = mem_readdata_l1;
    mem_read_l1  = 1'b0;
    mem_write_l1 = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (mem_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_readdata: got %h expected %h", mem_readdata, 32'h0);
    end
    tests_run++;
    if (mem_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busywait: got %b expected 0", mem_busywait);
    end
    tests_run++;
    if (mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_err: got %b expected 0", mem_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic bw;
    int e;
    logic [31:0] rd;
    req0(1'b0, 1'b1, 6'h0A, 32'hDEADBEEF, bw, e, rd);
    tests_run++;
    if (bw !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_busy_immediate: got %b expected 1", bw);
    end
    tests_run++;
    if (e != 6) begin
      tests_failed++;
      $display("FAIL wr_latency: got %0d edges expected 6", e);
    end
    req0(1'b1, 1'b0, 6'h0A, 32'h0, bw, e, rd);
    tests_run++;
    if (e != 6) begin
      tests_failed++;
      $display("FAIL rd_latency: got %0d edges expected 6", e);
    end
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL rd_data_0a: got %h expected %h", rd, 32'hDEADBEEF);
    end
  endtask

  task automatic test_back_to_back();
    logic bw;
    int e;
    logic [31:0] rd;
    // Put known contents at 6'h23 first; these are the "prior contents".
    req0(1'b0, 1'b1, 6'h23, 32'h55667788, bw, e, rd);
    @(negedge clock);
    mem_write     = 1'b1;
    mem_address   = 6'h03;
    mem_writedata = 32'h11223344;
    wait0(e);
    // We are now in DONE. Switch straight over to the fetch.
    mem_write   = 1'b0;
    mem_read    = 1'b1;
    mem_address = 6'h23;
    #1;
    tests_run++;
    if (mem_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_done_gap: got %b expected 0", mem_busywait);
    end
    @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (mem_busywait !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_busy_again: got %b expected 1", mem_busywait);
    end
    wait0(e);
    tests_run++;
    if (e != 6) begin
      tests_failed++;
      $display("FAIL b2b_fetch_latency: got %0d edges expected 6", e);
    end
    tests_run++;
    if (mem_readdata !== 32'h55667788) begin
      tests_failed++;
      $display("FAIL b2b_fetch_data: got %h expected %h", mem_readdata, 32'h55667788);
    end
    mem_read = 1'b0;
    req0(1'b1, 1'b0, 6'h03, 32'h0, bw, e, rd);
    tests_run++;
    if (rd !== 32'h11223344) begin
      tests_failed++;
      $display("FAIL b2b_writeback_data: got %h expected %h", rd, 32'h11223344);
    end
  endtask

  task automatic test_mid_busy_change();
    logic bw;
    int e;
    logic [31:0] rd;
    req0(1'b0, 1'b1, 6'h11, 32'h0BADBEEF, bw, e, rd);
    @(negedge clock);
    mem_write     = 1'b1;
    mem_address   = 6'h10;
    mem_writedata = 32'hAAAA5555;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    mem_address   = 6'h11;
    mem_writedata = 32'h12345678;
    wait0(e);
    mem_write = 1'b0;
    req0(1'b1, 1'b0, 6'h10, 32'h0, bw, e, rd);
    tests_run++;
    if (rd !== 32'hAAAA5555) begin
      tests_failed++;
      $display("FAIL midbusy_latched: got %h expected %h", rd, 32'hAAAA5555);
    end
    req0(1'b1, 1'b0, 6'h11, 32'h0, bw, e, rd);
    tests_run++;
    if (rd !== 32'h0BADBEEF) begin
      tests_failed++;
      $display("FAIL midbusy_untouched: got %h expected %h", rd, 32'h0BADBEEF);
    end
  endtask

  task automatic test_reset_abort();
    logic bw;
    int e;
    logic [31:0] rd;
    req0(1'b0, 1'b1, 6'h05, 32'h01020304, bw, e, rd);
    req0(1'b1, 1'b0, 6'h05, 32'h0, bw, e, rd);
    tests_run++;
    if (rd !== 32'h01020304) begin
      tests_failed++;
      $display("FAIL abort_preload: got %h expected %h", rd, 32'h01020304);
    end
    @(negedge clock);
    mem_write     = 1'b1;
    mem_address   = 6'h05;
    mem_writedata = 32'hCAFEF00D;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (mem_busywait !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_busy_before: got %b expected 1", mem_busywait);
    end
    reset     = 1'b1;
    mem_write = 1'b0;
    @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (mem_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_busy_after: got %b expected 0", mem_busywait);
    end
    tests_run++;
    if (mem_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL abort_readdata: got %h expected %h", mem_readdata, 32'h0);
    end
    reset = 1'b0;
    req0(1'b1, 1'b0, 6'h05, 32'h0, bw, e, rd);
    tests_run++;
    if (rd !== 32'h01020304) begin
      tests_failed++;
      $display("FAIL abort_not_committed: got %h expected %h", rd, 32'h01020304);
    end
  endtask

  task automatic test_illegal();
    logic bw;
    int e;
    logic [31:0] rd;
    @(negedge clock);
    mem_read    = 1'b1;
    mem_write   = 1'b1;
    mem_address = 6'h07;
    #1;
    tests_run++;
    if (mem_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_busy_comb: got %b expected 0", mem_busywait);
    end
    @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (mem_busywait !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_busy_after: got %b expected 0", mem_busywait);
    end
    tests_run++;
    if (mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_err_set: got %b expected 1", mem_err);
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(posedge clock);
    // A normal write still takes the full latency, so the FSM stayed IDLE.
    req0(1'b0, 1'b1, 6'h07, 32'h77777777, bw, e, rd);
    tests_run++;
    if (e != 6) begin
      tests_failed++;
      $display("FAIL illegal_no_state_change: got %0d edges expected 6", e);
    end
    tests_run++;
    if (mem_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL illegal_err_sticky: got %b expected 1", mem_err);
    end
    pulse_reset();
    tests_run++;
    if (mem_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL illegal_err_cleared: got %b expected 0", mem_err);
    end
  endtask

  task automatic test_latency_one();
    int e;
    logic [31:0] rd;
    req1(1'b0, 1'b1, 6'h01, 32'hA1A1A1A1, e, rd);
    tests_run++;
    if (e != 2) begin
      tests_failed++;
      $display("FAIL lat1_wr_latency: got %0d edges expected 2", e);
    end
    req1(1'b0, 1'b1, 6'h02, 32'hB2B2B2B2, e, rd);
    req1(1'b1, 1'b0, 6'h01, 32'h0, e, rd);
    tests_run++;
    if (e != 2) begin
      tests_failed++;
      $display("FAIL lat1_rd_latency: got %0d edges expected 2", e);
    end
    tests_run++;
    if (rd !== 32'hA1A1A1A1) begin
      tests_failed++;
      $display("FAIL lat1_rd_01: got %h expected %h", rd, 32'hA1A1A1A1);
    end
    req1(1'b1, 1'b0, 6'h02, 32'h0, e, rd);
    tests_run++;
    if (rd !== 32'hB2B2B2B2) begin
      tests_failed++;
      $display("FAIL lat1_rd_02: got %h expected %h", rd, 32'hB2B2B2B2);
    end
    req1(1'b1, 1'b0, 6'h01, 32'h0, e, rd);
`ifdef DMEM_ACCESS_CNT_EN
    tests_run++;
    if (rd_count_l1 !== 16'd3) begin
      tests_failed++;
      $display("FAIL lat1_rd_count: got %0d expected 3", rd_count_l1);
    end
    tests_run++;
    if (wr_count_l1 !== 16'd2) begin
      tests_failed++;
      $display("FAIL lat1_wr_count: got %0d expected 2", wr_count_l1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_mid_busy_change();
    test_reset_abort();
    test_illegal();
    test_latency_one();
    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
